// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg
// Shared encodings for the RV64I multi-cycle control path: sequencer states,
// major opcodes (also used by the immediate generator), instruction classes,
// and the datapath select codes driven by multicycle_control.
package rv_ctrl_pkg;

  // Sequencer states; the numeric values are visible on the debug state port.
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_t;

  // Major opcodes, instr[6:0].
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Instruction class, latched in DECODE and steering EXECUTE onward.
  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_R      = 4'd1,
    CLS_IALU   = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JAL    = 4'd6,
    CLS_JALR   = 4'd7,
    CLS_LUI    = 4'd8,
    CLS_AUIPC  = 4'd9
  } iclass_t;

  // pc_src codes.
  localparam logic [1:0] PC_SRC_PC4  = 2'd0;
  localparam logic [1:0] PC_SRC_ALU  = 2'd1;
  localparam logic [1:0] PC_SRC_JALR = 2'd2;

  // alu_src_a codes.
  localparam logic [1:0] A_SRC_RS1  = 2'd0;
  localparam logic [1:0] A_SRC_PC   = 2'd1;
  localparam logic [1:0] A_SRC_ZERO = 2'd2;

  // alu_src_b codes.
  localparam logic [1:0] B_SRC_RS2  = 2'd0;
  localparam logic [1:0] B_SRC_IMM  = 2'd1;
  localparam logic [1:0] B_SRC_FOUR = 2'd2;

  // alu_op codes.
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  // wb_sel codes.
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

endpackage

// File: rtl/opcode_class_decode.sv
// opcode_class_decode
// Combinational opcode classifier.
// Ports:
//   opcode  in  [6:0]  instr[6:0]
//   iclass  out        instruction class (CLS_NONE when unsupported)
//   illegal out        1 when the opcode is not one the core implements
module opcode_class_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    iclass,
  output logic       illegal
);

  // Map each supported major opcode to its class; everything else is illegal.
  always_comb begin
    iclass  = CLS_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_R:      iclass = CLS_R;
      OP_IALU:   iclass = CLS_IALU;
      OP_LOAD:   iclass = CLS_LOAD;
      OP_STORE:  iclass = CLS_STORE;
      OP_BRANCH: iclass = CLS_BRANCH;
      OP_JAL:    iclass = CLS_JAL;
      OP_JALR:   iclass = CLS_JALR;
      OP_LUI:    iclass = CLS_LUI;
      OP_AUIPC:  iclass = CLS_AUIPC;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle sequencer for the RV64I core: FETCH, DECODE, EXECUTE, MEM,
// WRITEBACK, plus a sticky TRAP for unsupported opcodes.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   instr [31:0]          instruction register (only the opcode is used here)
//   branch_taken          branch comparator result, used in EXECUTE
//   mem_ready             memory completes the current request
//   mem_req/mem_we/iord   unified memory port request, write, address select
//   ir_write, pc_write    instruction register / PC load enables
//   pc_src, alu_src_a, alu_src_b, alu_op, wb_sel   datapath selects
//   reg_write             register file write enable
//   illegal               unsupported opcode seen (held until reset)
//   state [2:0]           current state, for debug
module multicycle_control
  import rv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [2:0]  state
);

  state_t  state_q, state_d;
  iclass_t cls_q, dec_class;
  logic    dec_illegal;

  // The operand/immediate fields belong to the register file and immediate
  // generator; only the opcode matters to sequencing.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[31:7];

  opcode_class_decode u_decode (
    .opcode  (instr[6:0]),
    .iclass  (dec_class),
    .illegal (dec_illegal)
  );

  // State register. The class is captured in DECODE so later changes on
  // instr cannot disturb an instruction already in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      cls_q   <= CLS_NONE;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        cls_q <= dec_class;
      end
    end
  end

  // Next state and Moore output decode. While reset is high every output is
  // forced low so an outstanding memory request is dropped straight away.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SRC_PC4;
    alu_src_a = A_SRC_RS1;
    alu_src_b = B_SRC_RS2;
    alu_op    = ALU_ADD;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    illegal   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end

      ST_DECODE: begin
        state_d = dec_illegal ? ST_TRAP : ST_EXECUTE;
      end

      ST_EXECUTE: begin
        state_d = ST_WRITEBACK;
        case (cls_q)
          CLS_R: begin
            alu_src_b = B_SRC_RS2;
            alu_op    = ALU_FUNCT;
          end
          CLS_IALU: begin
            alu_src_b = B_SRC_IMM;
            alu_op    = ALU_FUNCT;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_b = B_SRC_IMM;
            state_d   = ST_MEM;
          end
          // The ALU forms the PC+imm target while the separate comparator
          // supplies branch_taken; a not-taken branch still writes PC+4.
          CLS_BRANCH: begin
            alu_src_a = A_SRC_PC;
            alu_src_b = B_SRC_IMM;
            pc_write  = 1'b1;
            pc_src    = branch_taken ? PC_SRC_ALU : PC_SRC_PC4;
            state_d   = ST_FETCH;
          end
          CLS_JAL, CLS_AUIPC: begin
            alu_src_a = A_SRC_PC;
            alu_src_b = B_SRC_IMM;
          end
          CLS_JALR: begin
            alu_src_b = B_SRC_IMM;
          end
          CLS_LUI: begin
            alu_src_a = A_SRC_ZERO;
            alu_src_b = B_SRC_IMM;
          end
          default: state_d = ST_TRAP;
        endcase
      end

      ST_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (cls_q == CLS_STORE);
        if (mem_ready) begin
          if (cls_q == CLS_LOAD) begin
            state_d = ST_WRITEBACK;
          end else begin
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end
        end
      end

      ST_WRITEBACK: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = ST_FETCH;
        case (cls_q)
          CLS_JAL: begin
            wb_sel = WB_PC4;
            pc_src = PC_SRC_ALU;
          end
          CLS_JALR: begin
            wb_sel = WB_PC4;
            pc_src = PC_SRC_JALR;
          end
          CLS_LOAD: wb_sel = WB_MEM;
          default:  wb_sel = WB_ALU;
        endcase
      end

      ST_TRAP: begin
        illegal = 1'b1;
      end

      default: state_d = ST_FETCH;
    endcase

    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      iord      = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_SRC_PC4;
      alu_src_a = A_SRC_RS1;
      alu_src_b = B_SRC_RS2;
      alu_op    = ALU_ADD;
      reg_write = 1'b0;
      wb_sel    = WB_ALU;
      illegal   = 1'b0;
    end
  end

  assign state = state_q;

endmodule
